// File: rtl/cp0_unit_pkg.sv
// Shared CP0 definitions: register numbers, exception codes and field positions.
// Also holds the EPC target helper used on exception entry.
package cp0_unit_pkg;

    localparam logic [4:0] REG_COUNT   = 5'd9;
    localparam logic [4:0] REG_COMPARE = 5'd11;
    localparam logic [4:0] REG_SR      = 5'd12;
    localparam logic [4:0] REG_CAUSE   = 5'd13;
    localparam logic [4:0] REG_EPC     = 5'd14;
    localparam logic [4:0] REG_PRID    = 5'd15;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    localparam int SR_IE        = 0;
    localparam int SR_EXL       = 1;
    localparam int SR_IM_LO     = 8;
    localparam int CAUSE_EXC_LO = 2;
    localparam int CAUSE_IP_LO  = 8;
    localparam int CAUSE_BD     = 31;

    // A delay-slot instruction restarts at its branch, one word earlier.
    function automatic logic [31:0] epc_target(input logic [31:0] pc, input logic bd);
        logic [31:0] t;
        t = bd ? pc - 32'd4 : pc;
        return {t[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer with a sticky match flag that drives ip[7].
// Loading Compare always clears the flag, even if a match happens that same cycle.
module cp0_timer (
    input  logic        clk,
    input  logic        reset,
    input  logic        count_we,
    input  logic        compare_we,
    input  logic [31:0] wdata,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        flag
);

    logic [31:0] count_nxt;

    assign count_nxt = count_we ? wdata : count + 32'd1;

    always_ff @(posedge clk) begin
        if (!reset) begin
            count   <= '0;
            compare <= 32'hFFFF_FFFF;
            flag    <= 1'b0;
        end else begin
            count <= count_nxt;
            if (compare_we) begin
                compare <= wdata;
                flag    <= 1'b0;
            end else if (count_nxt == compare) begin
                flag <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/cp0_unit.sv
// Coprocessor 0: SR/Cause/EPC/PRId plus optional Count/Compare timer.
// Arbitrates M-stage interrupts and exceptions into a single flush request.
module cp0_unit
    import cp0_unit_pkg::*;
#(
    parameter int          HW_INT_N = 6,
    parameter bit          TIMER_EN = 1'b1,
    parameter logic [31:0] PRID_VAL = 32'h0000_7007,
    parameter int          EXC_W    = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                we,
    input  logic [4:0]          addr,
    input  logic [31:0]         wdata,
    output logic [31:0]         rdata,
    input  logic [31:0]         pc_in,
    input  logic                bd_in,
    input  logic                exc_valid,
    input  logic [EXC_W-1:0]    exc_code,
    input  logic [HW_INT_N-1:0] hw_int,
    input  logic                eret,
    output logic                req,
    output logic [31:0]         epc_out
);

    logic [7:0]          sr_im;
    logic                sr_exl, sr_ie;
    logic                cause_bd;
    logic [4:0]          cause_exc;
    logic [1:0]          ip_sw;
    logic [HW_INT_N-1:0] hw_q;
    logic [31:0]         epc;
    logic [31:0]         count, compare;
    logic                tflag;
    logic [7:0]          ip_live, ip_cause;
    logic                int_req, exc_req, wr;
    logic [4:0]          exc5;

    assign exc5 = 5'(exc_code);

    // Requests use the live lines; Cause.IP shows the copy sampled last edge.
    always_comb begin
        ip_live  = '0;
        ip_cause = '0;
        ip_live[1:0]  = ip_sw;
        ip_cause[1:0] = ip_sw;
        for (int i = 0; i < HW_INT_N; i++) begin
            ip_live[2+i]  = hw_int[i];
            ip_cause[2+i] = hw_q[i];
        end
        if (TIMER_EN) begin
            ip_live[7]  = tflag;
            ip_cause[7] = tflag;
        end
    end

    assign int_req = (|(ip_live & sr_im)) & sr_ie & ~sr_exl;
    assign exc_req = exc_valid & ~sr_exl;
    assign req     = int_req | exc_req;
    assign wr      = we & ~req;
    assign epc_out = epc;

    generate
        if (TIMER_EN) begin : g_timer
            cp0_timer u_timer (
                .clk        (clk),
                .reset      (reset),
                .count_we   (wr && (addr == REG_COUNT)),
                .compare_we (wr && (addr == REG_COMPARE)),
                .wdata      (wdata),
                .count      (count),
                .compare    (compare),
                .flag       (tflag)
            );
        end else begin : g_no_timer
            assign count   = '0;
            assign compare = '0;
            assign tflag   = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!reset) begin
            sr_im     <= '0;
            sr_exl    <= 1'b0;
            sr_ie     <= 1'b0;
            cause_bd  <= 1'b0;
            cause_exc <= '0;
            ip_sw     <= '0;
            hw_q      <= '0;
            epc       <= '0;
        end else begin
            hw_q <= hw_int;
            if (wr) begin
                case (addr)
                    REG_SR: begin
                        sr_im  <= wdata[SR_IM_LO +: 8];
                        sr_exl <= wdata[SR_EXL];
                        sr_ie  <= wdata[SR_IE];
                    end
                    REG_CAUSE: ip_sw <= wdata[CAUSE_IP_LO +: 2];
                    REG_EPC:   epc   <= wdata;
                    default: ;
                endcase
            end
            if (eret) begin
                sr_exl <= 1'b0;
            end else if (req) begin
                sr_exl    <= 1'b1;
                cause_bd  <= bd_in;
                cause_exc <= int_req ? EXC_INT : exc5;
                epc       <= epc_target(pc_in, bd_in);
            end
        end
    end

    always_comb begin
        rdata = '0;
        case (addr)
            REG_SR: begin
                rdata[SR_IM_LO +: 8] = sr_im;
                rdata[SR_EXL]        = sr_exl;
                rdata[SR_IE]         = sr_ie;
            end
            REG_CAUSE: begin
                rdata[CAUSE_BD]          = cause_bd;
                rdata[CAUSE_IP_LO +: 8]  = ip_cause;
                rdata[CAUSE_EXC_LO +: 5] = cause_exc;
            end
            REG_EPC:     rdata = epc;
            REG_PRID:    rdata = PRID_VAL;
            REG_COUNT:   rdata = count;
            REG_COMPARE: rdata = compare;
            default: ;
        endcase
    end

endmodule
